// File: rtl/regfile_sb.sv
// Decode-stage integer register file: NUM_RD registered read ports with write bypass,
// plus a per-register pending (scoreboard) bit whose next state is reported with each read.
module regfile_sb #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WrEn,
  input  logic [DEPTH_BITS-1:0]        WrAddress,
  input  logic [WIDTH-1:0]             WrData,
  input  logic [NUM_RD*DEPTH_BITS-1:0] RdAddress,
  output logic [NUM_RD*WIDTH-1:0]      RdData,
  output logic [NUM_RD-1:0]            RdBusy,
  input  logic                         RsvEn,
  input  logic [DEPTH_BITS-1:0]        RsvAddress,
  input  logic                         Flush,
  output logic                         AnyBusy
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] pend_reg;
  logic [DEPTH-1:0] pend_next;
  logic             any_busy_reg;

  // Priority: flush clears everything, a new reservation beats a release by writeback.
  always_comb begin
    pend_next = pend_reg;
    for (int r = 0; r < DEPTH; r++) begin
      if (Flush)
        pend_next[r] = 1'b0;
      else if (RsvEn && (RsvAddress == DEPTH_BITS'(r)))
        pend_next[r] = 1'b1;
      else if (WrEn && (WrAddress == DEPTH_BITS'(r)))
        pend_next[r] = 1'b0;
    end
    if (ZERO_REG != 0)
      pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reg     <= '0;
      any_busy_reg <= 1'b0;
    end else begin
      pend_reg     <= pend_next;
      any_busy_reg <= |pend_next;
    end
  end

  assign AnyBusy = any_busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [DEPTH_BITS-1:0] ADDR = DEPTH_BITS'(gi);
      localparam bit WRITABLE = !((ZERO_REG != 0) && (gi == 0));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          mem_reg[gi] <= '0;
        else if (WRITABLE && WrEn && (WrAddress == ADDR))
          mem_reg[gi] <= WrData;
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [DEPTH_BITS-1:0] rd_addr;
      logic [WIDTH-1:0]      rd_sel;
      logic [WIDTH-1:0]      rd_data_reg;
      logic                  rd_busy_reg;

      assign rd_addr = RdAddress[gi*DEPTH_BITS +: DEPTH_BITS];

      // Zero register outranks the bypass, which outranks the stored value.
      always_comb begin
        rd_sel = mem_reg[rd_addr];
        if (WrEn && (WrAddress == rd_addr))
          rd_sel = WrData;
        if ((ZERO_REG != 0) && (rd_addr == '0))
          rd_sel = '0;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_reg <= '0;
          rd_busy_reg <= 1'b0;
        end else begin
          rd_data_reg <= rd_sel;
          rd_busy_reg <= pend_next[rd_addr];
        end
      end

      assign RdData[gi*WIDTH +: WIDTH] = rd_data_reg;
      assign RdBusy[gi]                = rd_busy_reg;
    end
  endgenerate

endmodule
